// File: rtl/anton_neopixel_regfile_pkg.sv
// Shared definitions for the NeoPixel register file: register offsets inside
// a channel's 8-byte register window, ctrl bit positions, clear-FSM encoding
// and the default pixel buffer depth.
package anton_neopixel_regfile_pkg;

  localparam int BUFFER_END_DEFAULT = 47;

  localparam logic [2:0] OFF_MAX_LO = 3'd0;
  localparam logic [2:0] OFF_MAX_HI = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATE  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_IRQEN  = 3'd5;

  localparam int CTRL_INIT  = 0;
  localparam int CTRL_LIMIT = 1;
  localparam int CTRL_RUN   = 2;
  localparam int CTRL_LOOP  = 3;
  localparam int CTRL_32BIT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // A single channel still needs one select bit so slices stay non-empty.
  function automatic int ch_bits(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/anton_neopixel_regfile_channel_regs.sv
// Per-channel control registers: max, ctrl, syncDone status and irqEn.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   init_clr_i              zero max/ctrl/syncDone (channel init)
//   sync_start_i, sync_of_i streamer events, already masked during clear
//   wr_en_i, off_i, wdata_i bus write into this channel's register window
//   state_i                 streamer status bit, readable at offset 3
//   rdata_o                 combinational read data for off_i
//   max_o, *_o ctrl bits    register outputs
//   irq_req_o               syncDone & irqEn
module anton_neopixel_channel_regs
  import anton_neopixel_regfile_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_clr_i,
  input  logic        sync_start_i,
  input  logic        sync_of_i,
  input  logic        wr_en_i,
  input  logic [2:0]  off_i,
  input  logic [7:0]  wdata_i,
  input  logic        state_i,
  output logic [7:0]  rdata_o,
  output logic [12:0] max_o,
  output logic        limit_o,
  output logic        run_o,
  output logic        loop_o,
  output logic        b32_o,
  output logic        irq_req_o
);

  logic [12:0] max_q, max_d;
  logic        limit_q, limit_d;
  logic        run_q, run_d;
  logic        loop_q, loop_d;
  logic        b32_q, b32_d;
  logic        done_q, done_d;
  logic        irqen_q, irqen_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_q   <= '0;
      limit_q <= 1'b0;
      run_q   <= 1'b0;
      loop_q  <= 1'b0;
      b32_q   <= 1'b0;
      done_q  <= 1'b0;
      irqen_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      limit_q <= limit_d;
      run_q   <= run_d;
      loop_q  <= loop_d;
      b32_q   <= b32_d;
      done_q  <= done_d;
      irqen_q <= irqen_d;
    end
  end

  // Later assignments override earlier ones, so the order below is the
  // priority order from lowest (bus write) to highest (init clear).
  always_comb begin
    max_d   = max_q;
    limit_d = limit_q;
    run_d   = run_q;
    loop_d  = loop_q;
    b32_d   = b32_q;
    done_d  = done_q;
    irqen_d = irqen_q;
    if (wr_en_i) begin
      case (off_i)
        OFF_MAX_LO: max_d[7:0]  = wdata_i;
        OFF_MAX_HI: max_d[12:8] = wdata_i[4:0];
        OFF_CTRL: begin
          run_d  = wdata_i[CTRL_RUN];
          loop_d = wdata_i[CTRL_LOOP];
          // Frame format bits are frozen while the streamer is running.
          if (!run_q) begin
            limit_d = wdata_i[CTRL_LIMIT];
            b32_d   = wdata_i[CTRL_32BIT];
          end
        end
        OFF_STATUS: if (wdata_i[0]) done_d = 1'b0;
        OFF_IRQEN:  irqen_d = wdata_i[0];
        default: ;
      endcase
    end
    if (sync_of_i) begin
      run_d  = loop_q;
      done_d = 1'b1;
    end
    if (sync_start_i) run_d = 1'b1;
    if (init_clr_i) begin
      max_d   = '0;
      limit_d = 1'b0;
      run_d   = 1'b0;
      loop_d  = 1'b0;
      b32_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    case (off_i)
      OFF_MAX_LO: rdata_o = max_q[7:0];
      OFF_MAX_HI: rdata_o = {3'b000, max_q[12:8]};
      OFF_CTRL:   rdata_o = {3'b000, b32_q, loop_q, run_q, limit_q, 1'b0};
      OFF_STATE:  rdata_o = {7'b0, state_i};
      OFF_STATUS: rdata_o = {7'b0, done_q};
      OFF_IRQEN:  rdata_o = {7'b0, irqen_q};
      default:    rdata_o = 8'h00;
    endcase
  end

  assign max_o     = max_q;
  assign limit_o   = limit_q;
  assign run_o     = run_q;
  assign loop_o    = loop_q;
  assign b32_o     = b32_q;
  assign irq_req_o = done_q & irqen_q;

endmodule

// File: rtl/anton_neopixel_regfile.sv
// NeoPixel register file: per-channel pixel byte memory plus control
// registers on a simple 14-bit byte bus, with a clear FSM that zeroes one
// channel's pixel memory one byte per cycle after an init write.
// Ports:
//   busClk, busRst                 clock, async active-high reset
//   busAddr/busDataIn/busWrite/busRead, busDataOut (registered), busReady
//   streamSyncOf, syncStart, state per-channel streamer events/status
//   pixelAddr, pixelData           per-channel streamer read port (1-cycle)
//   regMax, regCtrl*               per-channel register outputs
//   irq                            registered OR of enabled syncDone flags
module anton_neopixel_regfile
  import anton_neopixel_regfile_pkg::*;
#(
  parameter int  CHANNELS    = 2,
  parameter int  BUFFER_END  = BUFFER_END_DEFAULT,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
  localparam int CH_BITS     = ch_bits(CHANNELS)
) (
  input  logic                            busClk,
  input  logic                            busRst,
  input  logic [13:0]                     busAddr,
  input  logic [7:0]                      busDataIn,
  input  logic                            busWrite,
  input  logic                            busRead,
  output logic [7:0]                      busDataOut,
  output logic                            busReady,
  input  logic [CHANNELS-1:0]             streamSyncOf,
  input  logic [CHANNELS-1:0]             syncStart,
  input  logic [CHANNELS-1:0]             state,
  input  logic [CHANNELS*BUFFER_BITS-1:0] pixelAddr,
  output logic [CHANNELS*8-1:0]           pixelData,
  output logic [CHANNELS*13-1:0]          regMax,
  output logic [CHANNELS-1:0]             regCtrlLimit,
  output logic [CHANNELS-1:0]             regCtrlRun,
  output logic [CHANNELS-1:0]             regCtrlLoop,
  output logic [CHANNELS-1:0]             regCtrl32bit,
  output logic                            irq
);

  localparam int BB = BUFFER_BITS;
  localparam int CB = CH_BITS;

  logic [7:0]    mem [CHANNELS][BUFFER_END+1];

  clr_state_e    state_q, state_d;
  logic [CB-1:0] clr_ch_q, clr_ch_d;
  logic [BB-1:0] clr_idx_q, clr_idx_d;
  logic [7:0]    dout_q;
  logic          irq_q;

  logic [BB-1:0] pix_idx;
  logic [CB-1:0] pix_ch, reg_ch;
  logic [2:0]    reg_off;
  logic          is_reg, pix_ok, reg_ok;
  logic          bus_rd, bus_wr, pix_we, reg_we, init_req;
  logic [7:0]    rd_data;
  logic [7:0]    ch_rdata [CHANNELS];
  logic [CHANNELS-1:0] irq_req;
  logic          unused_addr;

  assign is_reg  = busAddr[13];
  assign pix_idx = busAddr[BB-1:0];
  assign pix_ch  = busAddr[BB+CB-1:BB];
  assign reg_ch  = busAddr[CB+2:3];
  assign reg_off = busAddr[2:0];
  // Upper address bits above the decoded fields simply alias.
  assign unused_addr = ^busAddr;

  assign pix_ok = (32'(pix_ch) < CHANNELS) && (32'(pix_idx) <= BUFFER_END);
  assign reg_ok = (32'(reg_ch) < CHANNELS);

  assign busReady = (state_q == ST_IDLE);
  assign bus_rd   = busRead & busReady;
  assign bus_wr   = busWrite & busReady;
  assign pix_we   = bus_wr & ~is_reg & pix_ok;
  assign reg_we   = bus_wr & is_reg & reg_ok;
  assign init_req = reg_we & (reg_off == OFF_CTRL) & busDataIn[CTRL_INIT];

  always_ff @(posedge busClk or posedge busRst) begin
    if (busRst) begin
      state_q   <= ST_IDLE;
      clr_ch_q  <= '0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ch_q  <= clr_ch_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ch_d  = clr_ch_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d   = ST_CLEAR;
          clr_ch_d  = reg_ch;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        if (32'(clr_idx_q) == BUFFER_END) state_d = ST_IDLE;
        else clr_idx_d = clr_idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel memory has no reset; a reset during a clear leaves it partly zeroed.
  always_ff @(posedge busClk) begin
    if (state_q == ST_CLEAR) mem[clr_ch_q][clr_idx_q] <= 8'h00;
    else if (pix_we) mem[pix_ch][pix_idx] <= busDataIn;
  end

  always_comb begin
    rd_data = 8'h00;
    if (is_reg) begin
      if (reg_ok) rd_data = ch_rdata[reg_ch];
    end else if (pix_ok) begin
      rd_data = mem[pix_ch][pix_idx];
    end
  end

  always_ff @(posedge busClk or posedge busRst) begin
    if (busRst) begin
      dout_q <= 8'h00;
      irq_q  <= 1'b0;
    end else begin
      if (bus_rd) dout_q <= rd_data;
      irq_q <= |irq_req;
    end
  end

  assign busDataOut = dout_q;
  assign irq        = irq_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          clearing;
    logic          ch_sel;
    logic [BB-1:0] paddr;
    logic [7:0]    pix_q;

    assign clearing = (state_q == ST_CLEAR) && (clr_ch_q == CB'(c));
    assign ch_sel   = (reg_ch == CB'(c));

    anton_neopixel_channel_regs u_regs (
      .clk_i        (busClk),
      .rst_i        (busRst),
      .init_clr_i   (init_req & ch_sel),
      .sync_start_i (syncStart[c] & ~clearing),
      .sync_of_i    (streamSyncOf[c] & ~clearing),
      .wr_en_i      (reg_we & ch_sel),
      .off_i        (reg_off),
      .wdata_i      (busDataIn),
      .state_i      (state[c]),
      .rdata_o      (ch_rdata[c]),
      .max_o        (regMax[c*13 +: 13]),
      .limit_o      (regCtrlLimit[c]),
      .run_o        (regCtrlRun[c]),
      .loop_o       (regCtrlLoop[c]),
      .b32_o        (regCtrl32bit[c]),
      .irq_req_o    (irq_req[c])
    );

    assign paddr = pixelAddr[c*BB +: BB];

    always_ff @(posedge busClk or posedge busRst) begin
      if (busRst) pix_q <= 8'h00;
      else pix_q <= (32'(paddr) <= BUFFER_END) ? mem[c][paddr] : 8'h00;
    end

    assign pixelData[c*8 +: 8] = pix_q;
  end

endmodule

// File: tb/tb_anton_neopixel_regfile.sv
module tb_anton_neopixel_regfile;

  localparam int CH = 2;
  localparam int BE = 47;
  localparam int BB = 6;

  logic              busClk = 1'b0;
  logic              busRst;
  logic [13:0]       busAddr;
  logic [7:0]        busDataIn;
  logic              busWrite;
  logic              busRead;
  logic [7:0]        busDataOut;
  logic              busReady;
  logic [CH-1:0]     streamSyncOf;
  logic [CH-1:0]     syncStart;
  logic [CH-1:0]     state;
  logic [CH*BB-1:0]  pixelAddr;
  logic [CH*8-1:0]   pixelData;
  logic [CH*13-1:0]  regMax;
  logic [CH-1:0]     regCtrlLimit;
  logic [CH-1:0]     regCtrlRun;
  logic [CH-1:0]     regCtrlLoop;
  logic [CH-1:0]     regCtrl32bit;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;

  anton_neopixel_regfile #(.CHANNELS(CH), .BUFFER_END(BE)) dut (
    .busClk       (busClk),
    .busRst       (busRst),
    .busAddr      (busAddr),
    .busDataIn    (busDataIn),
    .busWrite     (busWrite),
    .busRead      (busRead),
    .busDataOut   (busDataOut),
    .busReady     (busReady),
    .streamSyncOf (streamSyncOf),
    .syncStart    (syncStart),
    .state        (state),
    .pixelAddr    (pixelAddr),
    .pixelData    (pixelData),
    .regMax       (regMax),
    .regCtrlLimit (regCtrlLimit),
    .regCtrlRun   (regCtrlRun),
    .regCtrlLoop  (regCtrlLoop),
    .regCtrl32bit (regCtrl32bit),
    .irq          (irq)
  );

  always #5 busClk = ~busClk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge busClk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [7:0] d);
    busAddr   = a;
    busDataIn = d;
    busWrite  = 1'b1;
    tick();
    busWrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [7:0] d);
    busAddr = a;
    busRead = 1'b1;
    tick();
    busRead = 1'b0;
    d = busDataOut;
  endtask

  function automatic logic [3:0] ctrl0();
    return {regCtrl32bit[0], regCtrlLoop[0], regCtrlRun[0], regCtrlLimit[0]};
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int low, nz, guard;

    busRst = 1'b1; busAddr = '0; busDataIn = '0; busWrite = 1'b0; busRead = 1'b0;
    streamSyncOf = '0; syncStart = '0; state = '0; pixelAddr = '0;
    repeat (3) tick();
    check_eq("rst_dout", busDataOut, 8'h00);
    check_eq("rst_ready", busReady, 1'b1);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_max", regMax, 26'h0);
    check_eq("rst_ctrl", {regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit}, 8'h00);
    check_eq("rst_pix", pixelData, 16'h0000);
    busRst = 1'b0;
    tick();

    // max register split across two bytes
    bus_write(14'h2001, 8'h34);
    bus_write(14'h2000, 8'h12);
    bus_read(14'h2000, rd); check_eq("max_lo", rd, 8'h12);
    bus_read(14'h2001, rd); check_eq("max_hi", rd, 8'h14);
    check_eq("regmax0", regMax[12:0], 13'h1412);
    tick();
    check_eq("dout_hold", busDataOut, 8'h14);

    // simultaneous read and write returns old contents
    busAddr = 14'h2000; busDataIn = 8'h99; busWrite = 1'b1; busRead = 1'b1;
    tick();
    busWrite = 1'b0; busRead = 1'b0;
    check_eq("rw_pre", busDataOut, 8'h12);
    bus_read(14'h2000, rd); check_eq("rw_post", rd, 8'h99);

    // ch1: frame format locked while running
    bus_write(14'h200A, 8'h04);
    check_eq("run1_set", regCtrlRun[1], 1'b1);
    bus_write(14'h200A, 8'h1A);
    check_eq("lock_limit", regCtrlLimit[1], 1'b0);
    check_eq("lock_32bit", regCtrl32bit[1], 1'b0);
    check_eq("loop1", regCtrlLoop[1], 1'b1);
    streamSyncOf[1] = 1'b1; tick(); streamSyncOf = '0;
    check_eq("run1_loop", regCtrlRun[1], 1'b1);
    bus_read(14'h200C, rd); check_eq("status1", rd, 8'h01);

    // interrupt path
    bus_write(14'h200C, 8'h01); tick();
    check_eq("irq_idle", irq, 1'b0);
    bus_write(14'h200D, 8'h01);
    streamSyncOf[1] = 1'b1; tick(); streamSyncOf = '0; tick();
    check_eq("irq_set", irq, 1'b1);
    busAddr = 14'h200C; busDataIn = 8'h01; busWrite = 1'b1; streamSyncOf[1] = 1'b1;
    tick();
    busWrite = 1'b0; streamSyncOf = '0;
    tick();
    check_eq("irq_set_wins", irq, 1'b1);
    bus_read(14'h200C, rd); check_eq("w1c_vs_set", rd, 8'h01);
    bus_write(14'h200C, 8'h01); tick();
    check_eq("irq_w1c", irq, 1'b0);

    // ch0: format bits writable when stopped; syncStart beats bus run bit
    bus_write(14'h2002, 8'h1A);
    check_eq("ctrl0_wr", ctrl0(), 4'b1101);
    busAddr = 14'h2002; busDataIn = 8'h00; busWrite = 1'b1; syncStart[0] = 1'b1;
    tick();
    busWrite = 1'b0; syncStart = '0;
    check_eq("sync_vs_wr", ctrl0(), 4'b0010);
    bus_read(14'h2002, rd); check_eq("ctrl0_rd", rd, 8'h04);

    // status input, reserved offsets, out-of-range pixel index
    state = 2'b10;
    bus_read(14'h200B, rd); check_eq("state1", rd, 8'h01);
    bus_read(14'h0030, rd); check_eq("pix_oob_rd", rd, 8'h00);
    bus_read(14'h2003, rd); check_eq("state0", rd, 8'h00);
    bus_write(14'h2006, 8'hFF);
    bus_read(14'h2006, rd); check_eq("rsvd6", rd, 8'h00);

    // fill both channels
    for (int k = 0; k <= BE; k++) begin
      bus_write(14'(k), 8'hFF);
      bus_write(14'(k + 'h40), 8'(k + 'h80));
    end
    pixelAddr = {6'd2, 6'd5}; tick();
    check_eq("pix_port", pixelData, 16'h82FF);
    pixelAddr = {6'd2, 6'd48}; tick();
    check_eq("pix_port_oob", pixelData[7:0], 8'h00);
    pixelAddr = {6'd2, 6'd5};
    bus_read(14'h0040, rd); check_eq("ch1_byte0", rd, 8'h80);
    streamSyncOf[0] = 1'b1; tick(); streamSyncOf = '0;

    // channel 0 init clear
    bus_write(14'h2002, 8'h01);
    check_eq("init_max", regMax[12:0], 13'h0);
    check_eq("init_ctrl", ctrl0(), 4'b0000);
    low = 0;
    if (!busReady) low++;
    syncStart[0] = 1'b1; streamSyncOf[0] = 1'b1;
    bus_write(14'h0003, 8'hAA);
    syncStart = '0; streamSyncOf = '0;
    check_eq("sync_masked", ctrl0(), 4'b0000);
    if (!busReady) low++;
    bus_write(14'h2008, 8'h55);
    if (!busReady) low++;
    bus_read(14'h2000, rd); check_eq("dout_busy_hold", rd, 8'h80);
    guard = 0;
    while (!busReady && guard < 200) begin
      low++; guard++;
      tick();
    end
    check_eq("clear_cycles", low, BE + 1);
    nz = 0;
    for (int k = 0; k <= BE; k++) begin
      bus_read(14'(k), rd);
      if (rd != 8'h00) nz++;
    end
    check_eq("ch0_cleared", nz, 0);
    bus_read(14'h0043, rd); check_eq("ch1_kept", rd, 8'h83);
    bus_read(14'h2008, rd); check_eq("busy_wr_ignored", rd, 8'h00);
    bus_read(14'h2004, rd); check_eq("status0_clr", rd, 8'h00);
    check_eq("pix_after_clr", pixelData, 16'h8200);

    // reset in the middle of a clear
    streamSyncOf[1] = 1'b1; tick(); streamSyncOf = '0; tick();
    check_eq("pre_rst_irq", irq, 1'b1);
    bus_write(14'h2008, 8'h66);
    bus_read(14'h2008, rd); check_eq("pre_rst_dout", rd, 8'h66);
    for (int k = 0; k <= BE; k++) bus_write(14'(k), 8'hFF);
    bus_write(14'h2002, 8'h01);
    repeat (10) @(posedge busClk);
    #3 busRst = 1'b1;
    #1;
    check_eq("arst_dout", busDataOut, 8'h00);
    check_eq("arst_irq", irq, 1'b0);
    check_eq("arst_max", regMax, 26'h0);
    check_eq("arst_ready", busReady, 1'b1);
    check_eq("arst_pix", pixelData, 16'h0000);
    @(posedge busClk); #1;
    busRst = 1'b0;
    tick();
    bus_read(14'h0009, rd); check_eq("abort_idx9", rd, 8'h00);
    bus_read(14'h000A, rd); check_eq("abort_idx10", rd, 8'hFF);
    bus_read(14'h002F, rd); check_eq("abort_idx47", rd, 8'hFF);
    bus_read(14'h200D, rd); check_eq("arst_irqen", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_regfile.md
ANTON_NEOPIXEL_REGFILE -- requirements
Module: anton_neopixel_regfile

Interface
REQ-001 SHALL have parameter CHANNELS, 2, independent pixel channels (power of 2, 1..8).
REQ-002 SHALL have parameter BUFFER_END, `BUFFER_END_DEFAULT, last pixel-byte index per channel.
REQ-003 SHALL derive localparams BUFFER_BITS = `CLOG2(BUFFER_END+1) and CH_BITS = max(1,`CLOG2(CHANNELS)); BUFFER_BITS+CH_BITS <= 13.
REQ-004 SHALL have ports busClk in 1 sole clock; busRst in 1 asynchronous active-high reset.
REQ-005 SHALL have ports busAddr in 14; busDataIn in 8; busWrite in 1; busRead in 1; busDataOut out 8 registered; busReady out 1, low while clearing.
REQ-006 SHALL have ports streamSyncOf in CHANNELS; syncStart in CHANNELS; state in CHANNELS (per-channel streamer status).
REQ-007 SHALL have ports pixelAddr in CHANNELS*BUFFER_BITS; pixelData out CHANNELS*8 (per-channel streamer read port).
REQ-008 SHALL have ports regMax out CHANNELS*13; regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit out CHANNELS each; irq out 1.

Function
REQ-009 busAddr[13]=0 SHALL select pixel memory: channel = busAddr[BUFFER_BITS+CH_BITS-1:BUFFER_BITS], index = busAddr[BUFFER_BITS-1:0]; index > BUFFER_END writes ignored, reads return 0.
REQ-010 busAddr[13]=1 SHALL select registers: channel = busAddr[CH_BITS+2:3], offset = busAddr[2:0]; channel >= CHANNELS ignored, reads 0.
REQ-011 Offsets: 0 max[7:0]; 1 max[12:8] in bits 4:0; 2 ctrl {32bit,loop,run,limit,init} in bits 4:0; 3 {7'b0,state} RO; 4 status bit0 syncDone W1C; 5 irqEn bit0; 6-7 read 0, writes ignored.
REQ-012 Reads SHALL load busDataOut on the busRead edge (data valid next cycle); busDataOut SHALL hold otherwise.
REQ-013 busWrite and busRead together SHALL return pre-write data.
REQ-014 pixelData[c] SHALL register memory[c][pixelAddr[c]] every cycle (1-cycle latency), independent of bus traffic.
REQ-015 Writes to limit/32bit SHALL be ignored while that channel's run=1; other ctrl bits still written.
REQ-016 run priority per channel, highest first: init clear, syncStart (set 1), streamSyncOf (run <= loop), bus write.
REQ-017 syncStart SHALL NOT block concurrent bus accesses.
REQ-018 streamSyncOf[c] SHALL set syncDone[c]; set and W1C same cycle: set wins.
REQ-019 irq SHALL be registered OR over c of (syncDone[c] & irqEn[c]).
REQ-020 FSM states IDLE, CLEAR; writing init=1 to channel c in IDLE SHALL go to CLEAR, zero max/ctrl/syncDone of c, deassert busReady next cycle.
REQ-021 CLEAR SHALL zero memory[c][k] for k=0..BUFFER_END, one per cycle, then return to IDLE; busReady high the following cycle.
REQ-022 Bus reads/writes with busReady low SHALL be ignored (busDataOut holds); syncStart/streamSyncOf for c during CLEAR ignored, other channels unaffected.
REQ-023 init bit SHALL always read 0.

Reset
REQ-024 busRst SHALL asynchronously zero: all regMax, ctrl bits, syncDone, irqEn, busDataOut, pixelData, irq; FSM IDLE; busReady 1.
REQ-025 Pixel memory SHALL NOT be reset; busRst mid-CLEAR SHALL abort to IDLE, leaving memory partly cleared.

Structure
REQ-026 Register offsets, ctrl bit positions, FSM encodings SHALL live in anton_common.vh.
REQ-027 One sub-module anton_neopixel_channel_regs (per-channel max/ctrl/status/irqEn, priority logic), instantiated CHANNELS times via generate; memory and FSM in top.

Verification
REQ-028 Write 0x2001=0x34, 0x2000=0x12 (ch0), read 0x2000/0x2001 -> 0x12 then 0x14 one cycle after each busRead; regMax[12:0]=0x1412.
REQ-029 Ch1 run=1, write ctrl 0x1A -> limit,32bit stay 0, loop=1; streamSyncOf[1] pulse -> run stays 1, status 0x200C reads 1.
REQ-030 irqEn ch1=1, streamSyncOf[1] -> irq=1; write 0x200C=1 same cycle as next streamSyncOf[1] -> syncDone stays 1; later W1C alone -> irq 0.
REQ-031 Fill ch0 pixels 0xFF, write ctrl=0x01 -> busReady low exactly BUFFER_END+1 cycles, write during CLEAR ignored, then all ch0 bytes 0, ch1 untouched.
REQ-032 Assert busRst asynchronously mid-CLEAR -> outputs zero same cycle, busReady=1, remaining bytes keep 0xFF.
REQ-033 syncStart[0] with busWrite to ch0 ctrl=0x00 same cycle -> run=1, write to other bits applied.
